// File: rtl/ram_1p_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_1p_arbiter
// Purpose  : Shares one single-port 32-bit word RAM between the core
//            instruction-fetch port and the core data port. Round-robin
//            arbitration, byte-address to word-index translation,
//            out-of-range error flagging, 1-cycle response pipeline.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   AW        RAM word-address width (depth = 2**AW words)
//   MEM_BASE  byte address of RAM word 0
//   MEM_BYTES RAM window size in bytes (<= 4*2**AW, multiple of 4)
// Ports
//   clk_i, rst_ni                  clock, async active-low reset
//   instr_req_i/addr_i             fetch request (read only)
//   instr_gnt/rvalid/rdata/err_o   fetch grant and response
//   data_req/we/be/addr/wdata_i    data request
//   data_gnt/rvalid/rdata/err_o    data grant and response
//   ram_valid/addr/we/wdata_o      RAM access (one per cycle at most)
//   ram_rdata_i                    RAM read data, valid cycle after valid
// ============================================================================
module ram_1p_arbiter #(
  parameter int unsigned AW        = 16,
  parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
  parameter logic [31:0] MEM_BYTES = 32'h0004_0000
) (
  input  logic          clk_i,
  input  logic          rst_ni,

  input  logic          instr_req_i,
  input  logic [31:0]   instr_addr_i,
  output logic          instr_gnt_o,
  output logic          instr_rvalid_o,
  output logic [31:0]   instr_rdata_o,
  output logic          instr_err_o,

  input  logic          data_req_i,
  input  logic          data_we_i,
  input  logic [3:0]    data_be_i,
  input  logic [31:0]   data_addr_i,
  input  logic [31:0]   data_wdata_i,
  output logic          data_gnt_o,
  output logic          data_rvalid_o,
  output logic [31:0]   data_rdata_o,
  output logic          data_err_o,

  output logic          ram_valid_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [3:0]    ram_we_o,
  output logic [31:0]   ram_wdata_o,
  input  logic [31:0]   ram_rdata_i
);

  // Round-robin pointer encoding: which port won the most recent grant.
  localparam logic [0:0] PORT_INSTR = 1'b0;
  localparam logic [0:0] PORT_DATA  = 1'b1;

  // --------------------------------------------------------------------------
  // Arbitration state
  // --------------------------------------------------------------------------
  logic [0:0] last_q, last_d;

  // Response stage
  logic       instr_rvalid_q, instr_rvalid_d;
  logic       data_rvalid_q,  data_rvalid_d;
  logic       err_q,          err_d;
  // Set when the response must carry RAM read data (in-range read).
  logic       rd_q,           rd_d;

  // Combinational grant / access decode
  logic        gnt_instr;
  logic        gnt_data;
  logic        gnt_any;
  logic [31:0] sel_addr;
  logic [31:0] offset;
  logic [31:0] word_idx;
  logic        in_range;
  logic        ram_access;
  logic        is_write;

  // --------------------------------------------------------------------------
  // Grant: a lone requester wins; on a tie the port that did not win last
  // time wins. Both grants are held low while reset is asserted.
  // --------------------------------------------------------------------------
  always_comb begin
    gnt_instr = 1'b0;
    gnt_data  = 1'b0;
    if (rst_ni) begin
      if (instr_req_i && data_req_i) begin
        gnt_instr = (last_q == PORT_DATA);
        gnt_data  = (last_q == PORT_INSTR);
      end else begin
        gnt_instr = instr_req_i;
        gnt_data  = data_req_i;
      end
    end
  end

  assign gnt_any     = gnt_instr | gnt_data;
  assign instr_gnt_o = gnt_instr;
  assign data_gnt_o  = gnt_data;

  always_comb begin
    last_d = last_q;
    if (gnt_instr) begin
      last_d = PORT_INSTR;
    end else if (gnt_data) begin
      last_d = PORT_DATA;
    end
  end

  // --------------------------------------------------------------------------
  // Range check on the granted request. Unsigned 32-bit subtraction makes
  // addresses below MEM_BASE wrap to large offsets, so they fail the compare.
  // --------------------------------------------------------------------------
  assign sel_addr   = gnt_data ? data_addr_i : instr_addr_i;
  assign offset     = sel_addr - MEM_BASE;
  assign in_range   = (offset < MEM_BYTES);
  assign word_idx   = offset >> 2;
  assign ram_access = gnt_any && in_range;
  assign is_write   = gnt_data && data_we_i;

  // Offset bits above the RAM index and the byte lane bits do not address
  // the RAM; fold them into an explicitly unused net.
  generate
    if (AW < 30) begin : g_unused_hi
      logic unused_idx_hi;
      assign unused_idx_hi = ^{word_idx[31:AW], offset[1:0]};
    end else begin : g_unused_lo
      logic unused_idx_lo;
      assign unused_idx_lo = ^offset[1:0];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // RAM drive: all fields are zeroed whenever no access is issued.
  // --------------------------------------------------------------------------
  always_comb begin
    ram_valid_o = 1'b0;
    ram_addr_o  = '0;
    ram_we_o    = 4'b0000;
    ram_wdata_o = 32'h0;
    if (ram_access) begin
      ram_valid_o = 1'b1;
      ram_addr_o  = word_idx[AW-1:0];
      ram_we_o    = is_write ? data_be_i : 4'b0000;
      ram_wdata_o = data_wdata_i;
    end
  end

  // --------------------------------------------------------------------------
  // Response stage next-state: one rvalid per grant, one cycle later.
  // --------------------------------------------------------------------------
  always_comb begin
    instr_rvalid_d = gnt_instr;
    data_rvalid_d  = gnt_data;
    err_d          = gnt_any && !in_range;
    rd_d           = ram_access && !is_write;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q         <= PORT_DATA;
      instr_rvalid_q <= 1'b0;
      data_rvalid_q  <= 1'b0;
      err_q          <= 1'b0;
      rd_q           <= 1'b0;
    end else begin
      last_q         <= last_d;
      instr_rvalid_q <= instr_rvalid_d;
      data_rvalid_q  <= data_rvalid_d;
      err_q          <= err_d;
      rd_q           <= rd_d;
    end
  end

  // --------------------------------------------------------------------------
  // Response outputs. The RAM read data arrives in the response cycle, so it
  // is steered straight through rather than registered again.
  // --------------------------------------------------------------------------
  assign instr_rvalid_o = instr_rvalid_q;
  assign data_rvalid_o  = data_rvalid_q;
  assign instr_err_o    = instr_rvalid_q && err_q;
  assign data_err_o     = data_rvalid_q  && err_q;
  assign instr_rdata_o  = (instr_rvalid_q && rd_q) ? ram_rdata_i : 32'h0;
  assign data_rdata_o   = (data_rvalid_q  && rd_q) ? ram_rdata_i : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_ram_1p_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_1p_arbiter
// Purpose  : Directed self-checking bench for ram_1p_arbiter. A small RAM
//            fixture backs the main instance; a second instance with a
//            non-zero MEM_BASE exercises below-base wrap-around.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_1p_arbiter;

  localparam int unsigned AW = 16;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;

  logic          instr_req_i = 1'b0;
  logic [31:0]   instr_addr_i = 32'h0;
  logic          instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0]   instr_rdata_o;
  logic          data_req_i = 1'b0;
  logic          data_we_i = 1'b0;
  logic [3:0]    data_be_i = 4'h0;
  logic [31:0]   data_addr_i = 32'h0;
  logic [31:0]   data_wdata_i = 32'h0;
  logic          data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0]   data_rdata_o;
  logic          ram_valid_o;
  logic [AW-1:0] ram_addr_o;
  logic [3:0]    ram_we_o;
  logic [31:0]   ram_wdata_o;
  logic [31:0]   ram_rdata_i = 32'h0;

  // Second instance (MEM_BASE = 0x1000)
  logic          b_instr_req = 1'b0;
  logic [31:0]   b_instr_addr = 32'h0;
  logic          b_instr_gnt, b_instr_rvalid, b_instr_err;
  logic [31:0]   b_instr_rdata;
  logic          b_data_gnt, b_data_rvalid, b_data_err;
  logic [31:0]   b_data_rdata;
  logic          b_ram_valid;
  logic [AW-1:0] b_ram_addr;
  logic [3:0]    b_ram_we;
  logic [31:0]   b_ram_wdata;
  logic [31:0]   b_ram_rdata = 32'hA5A5_A5A5;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [0:255];

  always #5 clk_i = ~clk_i;

  ram_1p_arbiter #(.AW(AW), .MEM_BASE(32'h0), .MEM_BYTES(32'h0004_0000)) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
    .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
    .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .ram_valid_o(ram_valid_o), .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
  );

  ram_1p_arbiter #(.AW(AW), .MEM_BASE(32'h0000_1000), .MEM_BYTES(32'h0004_0000)) u_dut_b (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .instr_req_i(b_instr_req), .instr_addr_i(b_instr_addr),
    .instr_gnt_o(b_instr_gnt), .instr_rvalid_o(b_instr_rvalid),
    .instr_rdata_o(b_instr_rdata), .instr_err_o(b_instr_err),
    .data_req_i(1'b0), .data_we_i(1'b0), .data_be_i(4'h0),
    .data_addr_i(32'h0), .data_wdata_i(32'h0),
    .data_gnt_o(b_data_gnt), .data_rvalid_o(b_data_rvalid),
    .data_rdata_o(b_data_rdata), .data_err_o(b_data_err),
    .ram_valid_o(b_ram_valid), .ram_addr_o(b_ram_addr), .ram_we_o(b_ram_we),
    .ram_wdata_o(b_ram_wdata), .ram_rdata_i(b_ram_rdata)
  );

  // RAM fixture: registered read, per-byte write, indexed by low 8 bits.
  always @(posedge clk_i) begin
    if (ram_valid_o) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_we_o[b]) mem[ram_addr_o[7:0]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
      end
      ram_rdata_i <= mem[ram_addr_o[7:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    instr_req_i = 1'b0;
    data_req_i  = 1'b0;
    data_we_i   = 1'b0;
    data_be_i   = 4'h0;
    b_instr_req = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni      = 1'b0;
    instr_req_i = 1'b1;
    data_req_i  = 1'b1;
    #1;
    check("rst_instr_gnt", {31'b0, instr_gnt_o}, 32'd0);
    check("rst_data_gnt", {31'b0, data_gnt_o}, 32'd0);
    check("rst_ram_valid", {31'b0, ram_valid_o}, 32'd0);
    check("rst_rvalid", {30'b0, instr_rvalid_o, data_rvalid_o}, 32'd0);
    check("rst_err", {30'b0, instr_err_o, data_err_o}, 32'd0);
    check("rst_rdata", instr_rdata_o | data_rdata_o, 32'd0);
    idle();
    step();
    step();
    rst_ni = 1'b1;
    step();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[2] = 32'hFFFF_FFFF;
    mem[3] = 32'hCAFE_F00D;
    mem[4] = 32'hDEAD_BEEF;
    #2;
    do_reset();

    // Fetch of word 4
    instr_req_i = 1'b1; instr_addr_i = 32'h0000_0010;
    #1;
    check("f_gnt", {30'b0, instr_gnt_o, data_gnt_o}, 32'h2);
    check("f_ram_valid", {31'b0, ram_valid_o}, 32'd1);
    check("f_ram_addr", {16'b0, ram_addr_o}, 32'd4);
    check("f_ram_we", {28'b0, ram_we_o}, 32'd0);
    step(); idle(); #1;
    check("f_rvalid", {30'b0, instr_rvalid_o, data_rvalid_o}, 32'h2);
    check("f_rdata", instr_rdata_o, 32'hDEAD_BEEF);
    check("f_err", {31'b0, instr_err_o}, 32'd0);
    step();

    // Partial write then readback of word 2
    data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'b0011;
    data_addr_i = 32'h0000_0008; data_wdata_i = 32'h1234_5678;
    #1;
    check("w_gnt", {30'b0, instr_gnt_o, data_gnt_o}, 32'h1);
    check("w_ram_we", {28'b0, ram_we_o}, 32'h3);
    check("w_ram_addr", {16'b0, ram_addr_o}, 32'd2);
    check("w_ram_wdata", ram_wdata_o, 32'h1234_5678);
    step();
    data_we_i = 1'b0; data_be_i = 4'hF;
    #1;
    check("w_rvalid", {31'b0, data_rvalid_o}, 32'd1);
    check("w_rdata", data_rdata_o, 32'h0);
    check("w_err", {31'b0, data_err_o}, 32'd0);
    check("rd_gnt", {31'b0, data_gnt_o}, 32'd1);
    check("rd_ram_we", {28'b0, ram_we_o}, 32'd0);
    step(); idle(); #1;
    check("rd_rvalid", {31'b0, data_rvalid_o}, 32'd1);
    check("rd_rdata", data_rdata_o, 32'hFFFF_5678);
    step();

    // Round-robin tie from reset: I, D, I, D
    do_reset();
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin
        instr_req_i = 1'b1; instr_addr_i = 32'h0000_0010;
        data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h0000_000C;
      end else begin
        idle();
      end
      #1;
      if (k < 4) begin
        check($sformatf("rr_gnt%0d", k), {30'b0, instr_gnt_o, data_gnt_o},
              (k % 2 == 0) ? 32'h2 : 32'h1);
        check($sformatf("rr_addr%0d", k), {16'b0, ram_addr_o},
              (k % 2 == 0) ? 32'd4 : 32'd3);
      end
      if (k > 0) begin
        check($sformatf("rr_rvalid%0d", k - 1), {30'b0, instr_rvalid_o, data_rvalid_o},
              ((k - 1) % 2 == 0) ? 32'h2 : 32'h1);
        check($sformatf("rr_rdata%0d", k - 1), instr_rdata_o | data_rdata_o,
              ((k - 1) % 2 == 0) ? 32'hDEAD_BEEF : 32'hCAFE_F00D);
      end
      step();
    end

    // Out of range: data at MEM_BASE+MEM_BYTES; instr below base on instance B
    data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h0004_0000;
    b_instr_req = 1'b1; b_instr_addr = 32'hFFFF_FFFC;
    #1;
    check("oor_d_gnt", {31'b0, data_gnt_o}, 32'd1);
    check("oor_d_ram_valid", {31'b0, ram_valid_o}, 32'd0);
    check("oor_b_gnt", {31'b0, b_instr_gnt}, 32'd1);
    check("oor_b_ram_valid", {31'b0, b_ram_valid}, 32'd0);
    step(); idle(); #1;
    check("oor_d_resp", {29'b0, data_rvalid_o, data_err_o, instr_rvalid_o}, 32'h6);
    check("oor_d_rdata", data_rdata_o, 32'h0);
    check("oor_b_resp", {30'b0, b_instr_rvalid, b_instr_err}, 32'h3);
    check("oor_b_rdata", b_instr_rdata, 32'h0);
    step();
    // In-range access on instance B: 0x1010 maps to word 4
    b_instr_req = 1'b1; b_instr_addr = 32'h0000_1010;
    #1;
    check("b_in_addr", {15'b0, b_ram_valid, b_ram_addr}, 32'h0001_0004);
    step(); idle(); #1;
    check("b_in_rdata", b_instr_rdata, 32'hA5A5_A5A5);
    check("b_in_err", {31'b0, b_instr_err}, 32'd0);
    step();

    // Data alone for 3 cycles, instr joins: D, D, D, I, D
    do_reset();
    for (int k = 0; k < 5; k++) begin
      data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h0000_000C;
      instr_req_i = (k >= 3); instr_addr_i = 32'h0000_0010;
      #1;
      check($sformatf("join_gnt%0d", k), {30'b0, instr_gnt_o, data_gnt_o},
            (k == 3) ? 32'h2 : 32'h1);
      step();
    end
    idle();
    step();

    // Reset during an outstanding data read
    do_reset();
    data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h0000_000C;
    #1;
    check("mr_gnt", {31'b0, data_gnt_o}, 32'd1);
    @(negedge clk_i);
    idle();
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    check("mr_rvalid", {30'b0, instr_rvalid_o, data_rvalid_o}, 32'd0);
    step();
    rst_ni = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("mr_norvalid%0d", k), {30'b0, instr_rvalid_o, data_rvalid_o}, 32'd0);
    end
    instr_req_i = 1'b1; instr_addr_i = 32'h0000_0010;
    data_req_i = 1'b1;
    #1;
    check("mr_tie", {30'b0, instr_gnt_o, data_gnt_o}, 32'h2);
    step(); idle(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
